// File: rtl/joe_motion_pkg.sv
// Shared constants and types for Joe's motion controller, hit-test and color mapper.
// Screen geometry, sprite box, key codes and the motion state enum live here.
package joe_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int HALF_W     = 42;
  localparam int HALF_H     = 46;
  localparam int GROUND_Y   = SCREEN_H - 1 - HALF_H;
  localparam int WALK_V     = 3;
  localparam int JUMP_V     = 12;
  localparam int MAX_FALL_V = 12;
  localparam int SPAWN_X    = 320;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;

  // Signed 11-bit views of the clamp window so position math never wraps.
  localparam logic signed [10:0] X_LO      = 11'(HALF_W);
  localparam logic signed [10:0] X_HI      = 11'(SCREEN_W - 1 - HALF_W);
  localparam logic signed [10:0] Y_LO      = 11'(HALF_H);
  localparam logic signed [10:0] Y_HI      = 11'(GROUND_Y);
  localparam logic signed [10:0] WALK_STEP = 11'(WALK_V);

  localparam logic signed [5:0] JUMP_VY     = 6'(JUMP_V);
  localparam logic signed [5:0] FALL_VY_MAX = 6'(MAX_FALL_V);

  localparam logic [9:0] SPAWN_X_U  = 10'(SPAWN_X);
  localparam logic [9:0] GROUND_Y_U = 10'(GROUND_Y);
  localparam logic [9:0] HALF_H_U   = 10'(HALF_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } joe_state_t;

  function automatic logic key_hit(input logic [7:0] k0, input logic [7:0] k1,
                                   input logic [7:0] key);
    return (k0 == key) || (k1 == key);
  endfunction

  function automatic logic signed [10:0] clamp_s(input logic signed [10:0] v,
                                                 input logic signed [10:0] lo,
                                                 input logic signed [10:0] hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/joe_motion_if.sv
// Keyboard/vsync inputs and sprite position outputs of Joe's motion controller.
// master = keyboard/VGA side driving keys and vs; slave = the motion controller.
interface joe_motion_if;
  logic       vs;
  logic [7:0] keycode0;
  logic [7:0] keycode1;
  logic [9:0] centerx;
  logic [9:0] centery;
  logic       facing_left;
  logic       airborne;
  logic       frame_tick;

  modport master (
    output vs, keycode0, keycode1,
    input  centerx, centery, facing_left, airborne, frame_tick
  );

  modport slave (
    input  vs, keycode0, keycode1,
    output centerx, centery, facing_left, airborne, frame_tick
  );
endinterface

// File: rtl/joe_motion_vs_edge_detect.sv
// Rising-edge detector on VGA vsync; frame_tick marks the one Clk per frame
// on which Joe's motion state advances.
module vs_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic vs,
  output logic frame_tick
);

  logic vs_q_r;

  // Delay vsync by one clock for edge comparison.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q_r <= 1'b0;
    end else begin
      vs_q_r <= vs;
    end
  end

  assign frame_tick = vs & ~vs_q_r;

endmodule

// File: rtl/joe_motion.sv
// Frame-rate sprite motion for Joe: walk, jump, gravity and edge clamping.
// Optional mid-air second jump is enabled by defining DOUBLE_JUMP_EN.
module joe_motion
  import joe_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  joe_motion_if.slave bus
);

  logic              frame_tick_s;
  logic [9:0]        x_r, x_nxt_s;
  logic [9:0]        y_r, y_nxt_s;
  logic signed [5:0] vy_r, vy_nxt_s;
  joe_state_t        state_r, state_nxt_s;
  logic              face_r, face_nxt_s;
  logic              air_r, air_nxt_s;
  logic              w_prev_r;

  logic              left_s, right_s, w_s;
  logic              jump_edge_s, start_jump_s;
  logic signed [10:0] dx_s;
  logic signed [10:0] sum_y_s;
  logic signed [5:0]  vy_use_s, vy_inc_s;
  joe_state_t         eff_state_s, ground_state_s;

`ifdef DOUBLE_JUMP_EN
  logic dj_used_r, dj_nxt_s;
`endif

  vs_edge_detect u_vs_edge (
    .Clk        (Clk),
    .Reset      (Reset),
    .vs         (bus.vs),
    .frame_tick (frame_tick_s)
  );

  // Next-frame motion: key decode, horizontal step, vertical physics and clamps.
  always_comb begin
    left_s  = key_hit(bus.keycode0, bus.keycode1, KEY_A);
    right_s = key_hit(bus.keycode0, bus.keycode1, KEY_D);
    w_s     = key_hit(bus.keycode0, bus.keycode1, KEY_W);

    dx_s       = 11'sd0;
    face_nxt_s = face_r;
    if (left_s && !right_s) begin
      dx_s       = -WALK_STEP;
      face_nxt_s = 1'b1;
    end else if (right_s && !left_s) begin
      dx_s       = WALK_STEP;
      face_nxt_s = 1'b0;
    end else begin
      dx_s       = 11'sd0;
    end
    x_nxt_s = 10'(clamp_s($signed({1'b0, x_r}) + dx_s, X_LO, X_HI));

    jump_edge_s    = w_s & ~w_prev_r;
    ground_state_s = (dx_s != 11'sd0) ? WALK : IDLE;

    case (state_r)
      IDLE, WALK: start_jump_s = jump_edge_s;
`ifdef DOUBLE_JUMP_EN
      JUMP, FALL: start_jump_s = jump_edge_s & ~dj_used_r;
`else
      JUMP, FALL: start_jump_s = 1'b0;
`endif
      default:    start_jump_s = 1'b0;
    endcase

    // A jump applies its launch speed on the very tick it starts.
    vy_use_s    = start_jump_s ? -JUMP_VY : vy_r;
    eff_state_s = start_jump_s ? JUMP : state_r;
    sum_y_s     = $signed({1'b0, y_r}) + $signed({{5{vy_use_s[5]}}, vy_use_s});
    vy_inc_s    = vy_use_s + 6'sd1;

    state_nxt_s = state_r;
    y_nxt_s     = y_r;
    vy_nxt_s    = vy_r;
`ifdef DOUBLE_JUMP_EN
    dj_nxt_s    = dj_used_r;
    if (start_jump_s && (state_r == JUMP || state_r == FALL)) begin
      dj_nxt_s = 1'b1;
    end else begin
      dj_nxt_s = dj_used_r;
    end
`endif

    case (eff_state_s)
      IDLE, WALK: begin
        state_nxt_s = ground_state_s;
        vy_nxt_s    = 6'sd0;
        y_nxt_s     = y_r;
      end
      JUMP, FALL: begin
        if (sum_y_s < Y_LO) begin
          y_nxt_s     = HALF_H_U;
          vy_nxt_s    = 6'sd0;
          state_nxt_s = FALL;
        end else if (eff_state_s == FALL && sum_y_s >= Y_HI) begin
          y_nxt_s     = GROUND_Y_U;
          vy_nxt_s    = 6'sd0;
          state_nxt_s = ground_state_s;
`ifdef DOUBLE_JUMP_EN
          dj_nxt_s    = 1'b0;
`endif
        end else begin
          y_nxt_s = sum_y_s[9:0];
          if (eff_state_s == JUMP) begin
            vy_nxt_s    = vy_inc_s;
            state_nxt_s = vy_inc_s[5] ? JUMP : FALL;
          end else begin
            vy_nxt_s    = (vy_inc_s > FALL_VY_MAX) ? FALL_VY_MAX : vy_inc_s;
            state_nxt_s = FALL;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        vy_nxt_s    = 6'sd0;
        y_nxt_s     = GROUND_Y_U;
      end
    endcase

    air_nxt_s = (state_nxt_s == JUMP) || (state_nxt_s == FALL);
  end

  // Motion registers advance once per frame tick; Reset restores spawn.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_r      <= SPAWN_X_U;
      y_r      <= GROUND_Y_U;
      vy_r     <= 6'sd0;
      state_r  <= IDLE;
      face_r   <= 1'b0;
      air_r    <= 1'b0;
      w_prev_r <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      dj_used_r <= 1'b0;
`endif
    end else if (frame_tick_s) begin
      x_r      <= x_nxt_s;
      y_r      <= y_nxt_s;
      vy_r     <= vy_nxt_s;
      state_r  <= state_nxt_s;
      face_r   <= face_nxt_s;
      air_r    <= air_nxt_s;
      w_prev_r <= w_s;
`ifdef DOUBLE_JUMP_EN
      dj_used_r <= dj_nxt_s;
`endif
    end
  end

  assign bus.centerx     = x_r;
  assign bus.centery     = y_r;
  assign bus.facing_left = face_r;
  assign bus.airborne    = air_r;
  assign bus.frame_tick  = frame_tick_s;

endmodule

// File: tb/tb_joe_motion.sv
// Directed bench for joe_motion: a behavioural model pushes expected positions
// per frame into a scoreboard that is popped after each tick.
module tb_joe_motion;

  logic clk = 1'b0;
  logic reset;
  joe_motion_if bus();

  joe_motion dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit face;
    bit air;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int mx, my, mvy, mst;
  bit mface, mwprev, mdj;
  int jumps;
  bit air_prev;
  int ymin, xmax;

  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_D = 8'h07;
  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_0 = 8'h00;

  task automatic check(input string tag, input integer obs, input integer exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] key);
    return (k0 == key) || (k1 == key);
  endfunction

  task automatic model_reset();
    mx = 320; my = 433; mvy = 0; mst = 0;
    mface = 1'b0; mwprev = 1'b0; mdj = 1'b0;
  endtask

  // Reference physics: state 0 idle, 1 walk, 2 jump, 3 fall.
  task automatic model_step(input bit l, input bit r, input bit w);
    int dx;
    bit jedge;
    bit start;
    dx = 0;
    if (l && !r) begin dx = -3; mface = 1'b1; end
    else if (r && !l) begin dx = 3; mface = 1'b0; end
    jedge = w && !mwprev;
    mwprev = w;
    mx = mx + dx;
    if (mx < 42) mx = 42;
    if (mx > 597) mx = 597;
    start = 1'b0;
    if (mst < 2) start = jedge;
`ifdef DOUBLE_JUMP_EN
    else if (jedge && !mdj) begin start = 1'b1; mdj = 1'b1; end
`endif
    if (start) begin mvy = -12; mst = 2; end
    if (mst < 2) begin
      mst = (dx != 0) ? 1 : 0;
    end else if (my + mvy < 46) begin
      my = 46; mvy = 0; mst = 3;
    end else if (mst == 3 && my + mvy >= 433) begin
      my = 433; mvy = 0; mst = (dx != 0) ? 1 : 0; mdj = 1'b0;
    end else begin
      my = my + mvy;
      mvy = mvy + 1;
      if (mst == 2) begin
        if (mvy >= 0) mst = 3;
      end else if (mvy > 12) begin
        mvy = 12;
      end
    end
  endtask

  task automatic frame(input logic [7:0] k0, input logic [7:0] k1);
    exp_t e;
    @(negedge clk);
    bus.keycode0 = k0;
    bus.keycode1 = k1;
    bus.vs = 1'b1;
    model_step(hit(k0, k1, K_A), hit(k0, k1, K_D), hit(k0, k1, K_W));
    sb.push_back('{mx, my, mface, (mst >= 2)});
    #1 check("frame_tick", bus.frame_tick, 1);
    @(negedge clk);
    bus.vs = 1'b0;
    check("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("centerx", bus.centerx, e.x);
      check("centery", bus.centery, e.y);
      check("facing_left", bus.facing_left, e.face);
      check("airborne", bus.airborne, e.air);
    end
    if (bus.airborne && !air_prev) jumps++;
    air_prev = bus.airborne;
    if (bus.centerx > xmax) xmax = bus.centerx;
    if (bus.centery < ymin) ymin = bus.centery;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.vs = 1'b0;
    bus.keycode0 = K_0;
    bus.keycode1 = K_0;
    reset = 1'b1;
    model_reset();
    jumps = 0; air_prev = 1'b0; xmax = 0; ymin = 1000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_centerx", bus.centerx, 320);
    check("rst_centery", bus.centery, 433);
    check("rst_airborne", bus.airborne, 0);
    check("rst_facing", bus.facing_left, 0);
    check("no_tick_idle", bus.frame_tick, 0);

    repeat (3) frame(K_0, K_0);
    check("idle_x", bus.centerx, 320);
    check("idle_y", bus.centery, 433);
    check("idle_air", bus.airborne, 0);

    repeat (10) frame(K_D, K_0);
    check("walk_right_x", bus.centerx, 350);
    check("walk_right_face", bus.facing_left, 0);
    repeat (100) frame(K_D, K_0);
    check("right_sat_x", bus.centerx, 597);
    check("right_never_over", xmax, 597);

    frame(K_A, K_0);
    check("left_one_x", bus.centerx, 594);
    check("left_one_face", bus.facing_left, 1);
    repeat (5) frame(K_A, K_D);
    check("both_x", bus.centerx, 594);
    check("both_face", bus.facing_left, 1);

    // Single W pulse from the ground.
    ymin = 1000;
    frame(K_W, K_0);
    check("jump_t1", bus.centery, 421);
    frame(K_0, K_0);
    check("jump_t2", bus.centery, 410);
    frame(K_0, K_0);
    check("jump_t3", bus.centery, 400);
    for (int t = 4; t <= 24; t++) frame(K_0, K_0);
    check("jump_t24_air", bus.airborne, 1);
    check("jump_peak", ymin, 355);
    frame(K_0, K_0);
    check("land_t25_y", bus.centery, 433);
    check("land_t25_air", bus.airborne, 0);

    // W held: only one jump.
    jumps = 0; air_prev = bus.airborne;
    repeat (40) frame(K_0, K_W);
    check("held_w_jumps", jumps, 1);
    check("held_w_grounded", bus.airborne, 0);
    frame(K_0, K_0);

    // Second edge at tick 8, third edge at tick 10.
    frame(K_W, K_0);
    repeat (6) frame(K_0, K_0);
    frame(K_W, K_0);
`ifdef DOUBLE_JUMP_EN
    check("dj_t8_y", bus.centery, 358);
`else
    check("dj_t8_y", bus.centery, 365);
`endif
    frame(K_0, K_0);
    frame(K_0, K_W);
    repeat (40) frame(K_0, K_0);
    check("dj_landed", bus.airborne, 0);

    // Reset in the middle of a jump.
    repeat (4) frame(K_A, K_0);
    frame(K_W, K_0);
    repeat (4) frame(K_0, K_0);
    check("midjump_air", bus.airborne, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("midrst_x", bus.centerx, 320);
    check("midrst_y", bus.centery, 433);
    check("midrst_air", bus.airborne, 0);
    check("midrst_face", bus.facing_left, 0);
    repeat (3) frame(K_D, K_0);
    check("post_rst_x", bus.centerx, 329);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
